// File: rtl/voice_sched_pkg.sv
// Shared definitions for the voice scheduler: width defaults, register map and FSM states.
package synth_pkg;

  localparam int DEF_PHASE_W  = 21;
  localparam int DEF_SAMPLE_W = 16;

  localparam logic [1:0] OFS_INC_L = 2'd0;
  localparam logic [1:0] OFS_INC_M = 2'd1;
  localparam logic [1:0] OFS_INC_H = 2'd2;
  localparam logic [1:0] OFS_CTRL  = 2'd3;
  localparam logic [7:0] ADR_GLOBAL = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    ACCUM,
    OUTPUT
  } state_t;

endpackage

// File: rtl/voice_sched_if.sv
// Register write port, sine lookup and TX FIFO write side of the voice scheduler.
interface voice_sched_if #(
  parameter int ADDR_W   = 8,
  parameter int PHASE_W  = 21,
  parameter int SAMPLE_W = 16
);
  logic                reg_wr;
  logic [ADDR_W-1:0]   reg_adrs;
  logic [7:0]          reg_data;
  logic [PHASE_W-1:0]  phase;
  logic [SAMPLE_W-1:0] sine_in;
  logic                fifo_wrreq;
  logic [SAMPLE_W-1:0] fifo_data;
  logic                fifo_full;

  modport master (
    output reg_wr, reg_adrs, reg_data, sine_in, fifo_full,
    input  phase, fifo_wrreq, fifo_data
  );

  modport slave (
    input  reg_wr, reg_adrs, reg_data, sine_in, fifo_full,
    output phase, fifo_wrreq, fifo_data
  );
endinterface

// File: rtl/voice_sched_regfile.sv
// Per-voice tuning words (shadowed low bytes, atomic commit on the high byte) and control bits.
module voice_regfile
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int ADDR_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          reg_wr,
  input  logic [ADDR_W-1:0]             reg_adrs,
  input  logic [7:0]                    reg_data,
  input  logic [$clog2(NUM_VOICES)-1:0] sel,
  output logic [PHASE_W-1:0]            inc,
  output logic                          en,
  output logic [2:0]                    shift
);
  localparam int VI_W = $clog2(NUM_VOICES);

  logic [7:0]         shadow_l [NUM_VOICES];
  logic [7:0]         shadow_m [NUM_VOICES];
  logic [PHASE_W-1:0] inc_r    [NUM_VOICES];
  logic               en_r     [NUM_VOICES];
  logic [2:0]         shift_r  [NUM_VOICES];

  logic            hit;
  logic [VI_W-1:0] wv;
  logic [1:0]      ofs;

  always_comb begin
    wv  = reg_adrs[VI_W+1:2];
    ofs = reg_adrs[1:0];
    hit = reg_wr && (reg_adrs[ADDR_W-1:VI_W+2] == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        shadow_l[i] <= '0;
        shadow_m[i] <= '0;
        inc_r[i]    <= '0;
        en_r[i]     <= 1'b0;
        shift_r[i]  <= '0;
      end
    end else if (hit) begin
      case (ofs)
        OFS_INC_L: shadow_l[wv] <= reg_data;
        OFS_INC_M: shadow_m[wv] <= reg_data;
        // high-byte write commits the whole word so the oscillator never sees a torn increment
        OFS_INC_H: inc_r[wv] <= {reg_data[PHASE_W-17:0], shadow_m[wv], shadow_l[wv]};
        OFS_CTRL: begin
          en_r[wv]    <= reg_data[7];
          shift_r[wv] <= reg_data[2:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    inc   = inc_r[sel];
    en    = en_r[sel];
    shift = shift_r[sel];
  end

endmodule

// File: rtl/voice_sched.sv
// Time-shares one sine lookup across NUM_VOICES oscillators and writes one mixed word per frame.
// Define VOICE_SCHED_SAT_EN to clamp the mix to the sample range instead of wrapping.
module voice_sched
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int ADDR_W     = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  voice_sched_if.slave  bus,
  output logic          busy
);
  localparam int VI_W  = $clog2(NUM_VOICES);
  localparam int SUM_W = SAMPLE_W + VI_W;

  state_t                     state;
  logic [VI_W-1:0]            v;
  logic [PHASE_W-1:0]         acc [NUM_VOICES];
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    sum_nx;
  logic signed [SAMPLE_W-1:0] shifted;
  logic [VI_W:0]              sum_top;
  logic [SAMPLE_W-1:0]        mixed;
  logic [PHASE_W-1:0]         inc_v;
  logic                       en_v;
  logic [2:0]                 shift_v;
  logic                       run;
  logic                       clr_pend;

  voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W),
    .ADDR_W     (ADDR_W)
  ) u_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .reg_wr   (bus.reg_wr),
    .reg_adrs (bus.reg_adrs),
    .reg_data (bus.reg_data),
    .sel      (v),
    .inc      (inc_v),
    .en       (en_v),
    .shift    (shift_v)
  );

  // phase_clr stays pending until the FSM is idle, where the accumulators are zeroed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      if (state == IDLE)
        clr_pend <= 1'b0;
      if (bus.reg_wr && bus.reg_adrs == ADDR_W'(ADR_GLOBAL)) begin
        run <= bus.reg_data[0];
        if (bus.reg_data[1])
          clr_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    shifted = $signed(bus.sine_in) >>> shift_v;
    sum_nx  = sum;
    if (en_v)
      sum_nx = sum + $signed({{VI_W{shifted[SAMPLE_W-1]}}, shifted});
    sum_top = sum_nx[SUM_W-1:SAMPLE_W-1];
`ifdef VOICE_SCHED_SAT_EN
    if ((&sum_top) || (~|sum_top))
      mixed = sum_nx[SAMPLE_W-1:0];
    else if (sum_nx[SUM_W-1])
      mixed = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      mixed = {1'b0, {(SAMPLE_W-1){1'b1}}};
`else
    mixed = sum_nx[SAMPLE_W-1:0];
`endif
  end

  // sample word and write strobe are loaded together on the last ACCUM so both are valid in OUTPUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      v              <= '0;
      sum            <= '0;
      bus.phase      <= '0;
      bus.fifo_wrreq <= 1'b0;
      bus.fifo_data  <= '0;
      busy           <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++)
        acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          sum            <= '0;
          v              <= '0;
          bus.fifo_wrreq <= 1'b0;
          if (clr_pend) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++)
              acc[i] <= '0;
          end
          if (run && !bus.fifo_full) begin
            state <= PRESENT;
            busy  <= 1'b1;
          end
        end
        PRESENT: begin
          bus.phase <= acc[v];
          state     <= ACCUM;
        end
        ACCUM: begin
          sum    <= sum_nx;
          acc[v] <= acc[v] + inc_v;
          if (v == VI_W'(NUM_VOICES - 1)) begin
            bus.fifo_data  <= mixed;
            bus.fifo_wrreq <= 1'b1;
            state          <= OUTPUT;
          end else begin
            v     <= v + 1'b1;
            state <= PRESENT;
          end
        end
        OUTPUT: begin
          bus.fifo_wrreq <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_sched.sv
// Scoreboard bench for voice_sched: directed frames push expected words and voice-0 phases, a monitor checks them.
module tb_voice_sched;

`ifdef VOICE_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  voice_sched_if #(.ADDR_W(8), .PHASE_W(21), .SAMPLE_W(16)) vif ();

  voice_sched #(
    .NUM_VOICES (4),
    .PHASE_W    (21),
    .SAMPLE_W   (16),
    .ADDR_W     (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (vif),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  logic        force_en = 1'b0;
  logic [15:0] force_val = '0;
  always_comb vif.sine_in = force_en ? force_val : vif.phase[20:5];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fc = 0;
  int wr_count = 0;
  int last_wr = -1;
  bit gap_chk = 1'b0;

  logic [15:0] dq[$];
  logic [20:0] pq[$];
  logic [20:0] acc0_m = '0;
  logic [20:0] inc0_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: voice-0 phase in its ACCUM cycle, and every FIFO write
  always @(negedge clk) begin
    logic [20:0] pe;
    logic [15:0] de;
    if (busy === 1'b1) fc = fc + 1;
    else fc = 0;
    if (fc == 2) begin
      total++;
      if (pq.size() == 0) begin
        bad++;
        $display("FAIL phase_v0: got %h, no frame expected", vif.phase);
      end else begin
        pe = pq.pop_front();
        if (vif.phase !== pe) begin
          bad++;
          $display("FAIL phase_v0: got %h want %h", vif.phase, pe);
        end
      end
    end
    if (vif.fifo_wrreq === 1'b1) begin
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL fifo_data: unexpected write of %h", vif.fifo_data);
      end else begin
        de = dq.pop_front();
        if (vif.fifo_data !== de) begin
          bad++;
          $display("FAIL fifo_data: got %h want %h", vif.fifo_data, de);
        end
      end
      wr_count++;
      if (gap_chk && last_wr >= 0) begin
        total++;
        if (cyc - last_wr != 10) begin
          bad++;
          $display("FAIL wr_gap: got %0d want 10", cyc - last_wr);
        end
      end
      last_wr = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    vif.reg_wr = 1'b1;
    vif.reg_adrs = a;
    vif.reg_data = d;
    @(posedge clk); #1;
    vif.reg_wr = 1'b0;
  endtask

  task automatic set_inc(input int unsigned voice, input logic [20:0] val);
    logic [7:0] base;
    base = 8'(voice * 4);
    wr(base, val[7:0]);
    wr(base + 8'd1, val[15:8]);
    wr(base + 8'd2, {3'b000, val[20:16]});
    if (voice == 0) inc0_m = val;
  endtask

  task automatic push_frame(input logic [15:0] d);
    dq.push_back(d);
    pq.push_back(acc0_m);
    acc0_m = acc0_m + inc0_m;
  endtask

  task automatic push_stub();
    push_frame(acc0_m[20:5]);
  endtask

  task automatic wait_busy(input logic val, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === val) return;
    end
    total++;
    bad++;
    $display("FAIL %s: busy timeout, got %b want %b", tag, busy, val);
  endtask

  task automatic run_frames(input int n);
    wr(8'h80, 8'h01);
    for (int k = 0; k < n; k++) begin
      wait_busy(1'b1, "frame_start");
      if (k == n - 1) wr(8'h80, 8'h00);
      wait_busy(1'b0, "frame_end");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr0;
    int bz;
    int lat;
    vif.reg_wr = 1'b0;
    vif.reg_adrs = '0;
    vif.reg_data = '0;
    vif.fifo_full = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_phase", 32'(vif.phase), 0);
    chk("rst_wrreq", 32'(vif.fifo_wrreq), 0);
    chk("rst_data", 32'(vif.fifo_data), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;

    // 1: single voice ramp, back-to-back frames 10 cycles apart
    set_inc(0, 21'h000400);
    wr(8'h03, 8'h80);
    push_frame(16'h0000);
    push_frame(16'h0020);
    push_frame(16'h0040);
    last_wr = -1;
    gap_chk = 1'b1;
    run_frames(3);
    gap_chk = 1'b0;

    // 2: phase_clr, preload near the top, then wrap through zero
    wr(8'h80, 8'h02);
    acc0_m = '0;
    set_inc(0, 21'h1FFC00);
    push_frame(16'h0000);
    run_frames(1);
    set_inc(0, 21'h000400);
    push_frame(16'hFFE0);
    push_frame(16'h0000);
    push_frame(16'h0020);
    run_frames(3);

    // 3: four voices at full scale, then per-voice arithmetic shifts
    force_en = 1'b1;
    wr(8'h03, 8'h80); wr(8'h07, 8'h80); wr(8'h0B, 8'h80); wr(8'h0F, 8'h80);
    force_val = 16'h7FFF; push_frame(SAT ? 16'h7FFF : 16'hFFFC); run_frames(1);
    force_val = 16'h8000; push_frame(SAT ? 16'h8000 : 16'h0000); run_frames(1);
    wr(8'h07, 8'h81); wr(8'h0B, 8'h82); wr(8'h0F, 8'h83);
    force_val = 16'h8000; push_frame(SAT ? 16'h8000 : 16'h1000); run_frames(1);
    force_val = 16'h7FFF; push_frame(SAT ? 16'h7FFF : 16'hEFFC); run_frames(1);
    force_val = 16'h1000; push_frame(16'h1E00); run_frames(1);
    force_val = 16'hF000; push_frame(16'hE200); run_frames(1);
    wr(8'h0F, 8'h03);
    force_val = 16'h1000; push_frame(16'h1C00); run_frames(1);

    // 4: FIFO backpressure in IDLE, release latency, full rising mid-frame
    vif.fifo_full = 1'b1;
    nwr0 = wr_count;
    wr(8'h80, 8'h01);
    bz = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy) bz++;
    end
    chk("full_hold_wr", 32'(wr_count - nwr0), 0);
    chk("full_hold_busy", 32'(bz), 0);
    push_frame(16'h1C00);
    @(posedge clk); #1;
    vif.fifo_full = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (vif.fifo_wrreq === 1'b1) break;
    end
    chk("release_latency", 32'(lat), 10);
    push_frame(16'h1C00);
    wait_busy(1'b1, "frameB_start");
    nwr0 = wr_count;
    @(negedge clk);
    @(negedge clk);
    vif.fifo_full = 1'b1;
    wait_busy(1'b0, "frameB_end");
    repeat (30) @(negedge clk);
    chk("full_midframe_wr", 32'(wr_count - nwr0), 1);
    wr(8'h80, 8'h00);
    vif.fifo_full = 1'b0;

    // 5: shadowed increment bytes take effect only on the high-byte commit
    force_en = 1'b0;
    wr(8'h03, 8'h80); wr(8'h07, 8'h00); wr(8'h0B, 8'h00); wr(8'h0F, 8'h00);
    wr(8'h00, 8'h00);
    wr(8'h01, 8'h10);
    push_stub();
    run_frames(1);
    wr(8'h02, 8'h01);
    inc0_m = 21'h011000;
    push_stub();
    push_stub();
    run_frames(2);

    // 6: run cleared at cycle 4 finishes the frame; reset mid-frame aborts it
    push_stub();
    nwr0 = wr_count;
    wr(8'h80, 8'h01);
    wait_busy(1'b1, "stop_start");
    repeat (3) @(negedge clk);
    wr(8'h80, 8'h00);
    wait_busy(1'b0, "stop_end");
    repeat (30) @(negedge clk);
    chk("run_clear_wr", 32'(wr_count - nwr0), 1);

    pq.push_back(acc0_m);
    nwr0 = wr_count;
    wr(8'h80, 8'h01);
    wait_busy(1'b1, "rst_frame_start");
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_phase", 32'(vif.phase), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wrreq", 32'(vif.fifo_wrreq), 0);
    chk("midrst_data", 32'(vif.fifo_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_wr", 32'(wr_count - nwr0), 0);

    // configuration must be back to reset values: everything disabled, zero increments
    acc0_m = '0;
    inc0_m = '0;
    force_en = 1'b1;
    force_val = 16'h1000;
    push_frame(16'h0000);
    run_frames(1);
    repeat (5) @(negedge clk);
    chk("queues_drained", 32'(dq.size() + pq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
